// File: rtl/stg_ma_if.sv
// Pipeline bundle between EX, the MA stage and MO: EX-side fields in, MO-side fields
// out, plus the per-port memory addresses and the fault report.
interface stg_ma_if #(
    parameter int SIZE_ADDR   = 48,
    parameter int SIZE_DATA   = 24,
    parameter int SIZE_OPC    = 8,
    parameter int SIZE_TGT_GP = 4,
    parameter int SIZE_TGT_SR = 4,
    parameter int SIZE_TGT_AR = 4,
    parameter int P_FCNT_W    = 16
);
    logic                   iw_stall;
    logic                   iw_flush;
    logic [SIZE_ADDR-1:0]   iw_pc,        ow_pc;
    logic [SIZE_DATA-1:0]   iw_instr,     ow_instr;
    logic [SIZE_OPC-1:0]    iw_root_opc,  ow_root_opc;
    logic [SIZE_OPC-1:0]    iw_opc,       ow_opc;
    logic [SIZE_TGT_GP-1:0] iw_tgt_gp,    ow_tgt_gp;
    logic                   iw_tgt_gp_we, ow_tgt_gp_we;
    logic [SIZE_TGT_SR-1:0] iw_tgt_sr,    ow_tgt_sr;
    logic                   iw_tgt_sr_we, ow_tgt_sr_we;
    logic [SIZE_TGT_AR-1:0] iw_tgt_ar,    ow_tgt_ar;
    logic                   iw_tgt_ar_we, ow_tgt_ar_we;
    logic [SIZE_ADDR-1:0]   iw_addr;
    logic [SIZE_DATA-1:0]   iw_result,    ow_result;
    logic [SIZE_ADDR-1:0]   iw_sr_result, ow_sr_result;
    logic [SIZE_ADDR-1:0]   iw_ar_result, ow_ar_result;
    logic [SIZE_ADDR-1:0]   iw_cr_base;
    logic [SIZE_ADDR-1:0]   iw_cr_len;
    logic                   iw_trap_pending, ow_trap_pending;
    logic                   ow_sr_aux_we;
    logic [SIZE_TGT_SR-1:0] ow_sr_aux_addr;
    logic [SIZE_ADDR-1:0]   ow_sr_aux_result;
    logic [SIZE_ADDR-1:0]   ow_mem_addr [0:1];
    logic                   ow_mem_mp;
    logic [P_FCNT_W-1:0]    ow_fault_cnt;

    modport master (
        output iw_stall, iw_flush, iw_pc, iw_instr, iw_root_opc, iw_opc,
               iw_tgt_gp, iw_tgt_gp_we, iw_tgt_sr, iw_tgt_sr_we, iw_tgt_ar, iw_tgt_ar_we,
               iw_addr, iw_result, iw_sr_result, iw_ar_result, iw_cr_base, iw_cr_len,
               iw_trap_pending,
        input  ow_pc, ow_instr, ow_root_opc, ow_opc,
               ow_tgt_gp, ow_tgt_gp_we, ow_tgt_sr, ow_tgt_sr_we, ow_tgt_ar, ow_tgt_ar_we,
               ow_result, ow_sr_result, ow_ar_result, ow_trap_pending,
               ow_sr_aux_we, ow_sr_aux_addr, ow_sr_aux_result,
               ow_mem_addr, ow_mem_mp, ow_fault_cnt
    );

    modport slave (
        input  iw_stall, iw_flush, iw_pc, iw_instr, iw_root_opc, iw_opc,
               iw_tgt_gp, iw_tgt_gp_we, iw_tgt_sr, iw_tgt_sr_we, iw_tgt_ar, iw_tgt_ar_we,
               iw_addr, iw_result, iw_sr_result, iw_ar_result, iw_cr_base, iw_cr_len,
               iw_trap_pending,
        output ow_pc, ow_instr, ow_root_opc, ow_opc,
               ow_tgt_gp, ow_tgt_gp_we, ow_tgt_sr, ow_tgt_sr_we, ow_tgt_ar, ow_tgt_ar_we,
               ow_result, ow_sr_result, ow_ar_result, ow_trap_pending,
               ow_sr_aux_we, ow_sr_aux_addr, ow_sr_aux_result,
               ow_mem_addr, ow_mem_mp, ow_fault_cnt
    );
endinterface

// File: rtl/stg_ma.sv
// Memory-address stage: drives EX's effective address on the alternating memory port,
// bounds-checks it against the capability window and turns violations into traps.
module stg_ma #(
    parameter int SIZE_ADDR   = 48,
    parameter int SIZE_DATA   = 24,
    parameter int SIZE_OPC    = 8,
    parameter int SIZE_TGT_GP = 4,
    parameter int SIZE_TGT_SR = 4,
    parameter int SIZE_TGT_AR = 4,
    parameter int P_FAULT_SR  = 3,
    parameter int P_FCNT_W    = 16
) (
    input logic    iw_clk,
    input logic    iw_rst,
    stg_ma_if.slave bus
);
    localparam logic [SIZE_OPC-1:0] OPC_LDcso  = SIZE_OPC'(8'h10);
    localparam logic [SIZE_OPC-1:0] OPC_STui   = SIZE_OPC'(8'h11);
    localparam logic [SIZE_OPC-1:0] OPC_STsi   = SIZE_OPC'(8'h12);
    localparam logic [SIZE_OPC-1:0] OPC_STcso  = SIZE_OPC'(8'h13);
    localparam logic [SIZE_OPC-1:0] OPC_SRLDso = SIZE_OPC'(8'h20);
    localparam logic [SIZE_OPC-1:0] OPC_SRSTso = SIZE_OPC'(8'h21);

    logic                 r_mp;
    logic                 is_wide;
    logic                 is_mem;
    logic                 check_en;
    logic                 lo_ok;
    logic                 hi_ok;
    logic                 fault;
    logic                 drive;
    logic [SIZE_ADDR:0]   acc_end;
    logic [SIZE_ADDR:0]   win_end;

    // One extra bit on both end sums so a window or access running past the top of
    // the address space cannot wrap around and look in-range.
    always_comb begin
        is_wide  = (bus.iw_opc == OPC_SRLDso) || (bus.iw_opc == OPC_SRSTso);
        is_mem   = is_wide || (bus.iw_opc == OPC_LDcso) || (bus.iw_opc == OPC_STui)
                   || (bus.iw_opc == OPC_STsi) || (bus.iw_opc == OPC_STcso);
        acc_end  = {1'b0, bus.iw_addr} + (is_wide ? (SIZE_ADDR+1)'(2) : (SIZE_ADDR+1)'(1));
        win_end  = {1'b0, bus.iw_cr_base} + {1'b0, bus.iw_cr_len};
        lo_ok    = bus.iw_addr >= bus.iw_cr_base;
        hi_ok    = acc_end <= win_end;
        check_en = is_mem && !bus.iw_trap_pending;
        fault    = check_en && ((bus.iw_cr_len == '0) || !(lo_ok && hi_ok));
        drive    = check_en && !fault;
    end

    assign bus.ow_mem_addr[0] = (drive && !r_mp) ? bus.iw_addr : '0;
    assign bus.ow_mem_addr[1] = (drive &&  r_mp) ? bus.iw_addr : '0;

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_mp                 <= 1'b0;
            bus.ow_mem_mp        <= 1'b0;
            bus.ow_pc            <= '0;
            bus.ow_instr         <= '0;
            bus.ow_root_opc      <= '0;
            bus.ow_opc           <= '0;
            bus.ow_tgt_gp        <= '0;
            bus.ow_tgt_gp_we     <= 1'b0;
            bus.ow_tgt_sr        <= '0;
            bus.ow_tgt_sr_we     <= 1'b0;
            bus.ow_tgt_ar        <= '0;
            bus.ow_tgt_ar_we     <= 1'b0;
            bus.ow_result        <= '0;
            bus.ow_sr_result     <= '0;
            bus.ow_ar_result     <= '0;
            bus.ow_trap_pending  <= 1'b0;
            bus.ow_sr_aux_we     <= 1'b0;
            bus.ow_sr_aux_addr   <= '0;
            bus.ow_sr_aux_result <= '0;
            bus.ow_fault_cnt     <= '0;
        end else if (bus.iw_flush || !bus.iw_stall) begin
            r_mp              <= ~r_mp;
            bus.ow_mem_mp     <= r_mp;
            bus.ow_pc         <= bus.iw_pc;
            bus.ow_instr      <= bus.iw_instr;
            bus.ow_tgt_gp     <= bus.iw_tgt_gp;
            bus.ow_tgt_sr     <= bus.iw_tgt_sr;
            bus.ow_tgt_ar     <= bus.iw_tgt_ar;
            bus.ow_result     <= bus.iw_result;
            bus.ow_sr_result  <= bus.iw_sr_result;
            bus.ow_ar_result  <= bus.iw_ar_result;
            if (bus.iw_flush) begin
                bus.ow_opc          <= '0;
                bus.ow_root_opc     <= '0;
                bus.ow_tgt_gp_we    <= 1'b0;
                bus.ow_tgt_sr_we    <= 1'b0;
                bus.ow_tgt_ar_we    <= 1'b0;
                bus.ow_trap_pending <= 1'b0;
                bus.ow_sr_aux_we    <= 1'b0;
            end else if (fault) begin
                bus.ow_opc           <= '0;
                bus.ow_root_opc      <= '0;
                bus.ow_tgt_gp_we     <= 1'b0;
                bus.ow_tgt_sr_we     <= 1'b0;
                bus.ow_tgt_ar_we     <= 1'b0;
                bus.ow_trap_pending  <= 1'b1;
                bus.ow_sr_aux_we     <= 1'b1;
                bus.ow_sr_aux_addr   <= SIZE_TGT_SR'(P_FAULT_SR);
                bus.ow_sr_aux_result <= bus.iw_addr;
                if (bus.ow_fault_cnt != '1)
                    bus.ow_fault_cnt <= bus.ow_fault_cnt + 1'b1;
            end else begin
                bus.ow_opc          <= bus.iw_opc;
                bus.ow_root_opc     <= bus.iw_root_opc;
                bus.ow_tgt_gp_we    <= bus.iw_tgt_gp_we;
                bus.ow_tgt_sr_we    <= bus.iw_tgt_sr_we;
                bus.ow_tgt_ar_we    <= bus.iw_tgt_ar_we;
                bus.ow_trap_pending <= bus.iw_trap_pending;
                bus.ow_sr_aux_we    <= 1'b0;
            end
        end
    end
endmodule
